// File: rtl/servo_pwm_pkg.sv
// Shared constants and bus-slicing helper for the servo PWM generator.
package servo_pwm_pkg;

  localparam int NCH_DEF = 8;
  localparam int W_DEF   = 32;

  // LSB of channel k inside a flattened NCH*w bus.
  function automatic int CH_LSB(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/servo_pwm_if.sv
// Register-file to PWM-core signal bundle; the bus side is master, the core is slave.
interface servo_pwm_if #(
  parameter int NCH = servo_pwm_pkg::NCH_DEF,
  parameter int W   = servo_pwm_pkg::W_DEF
);
  // Handshake: upd_i[k] and sync_i are single-cycle strobes with no back-pressure;
  // the core always accepts them, and pend_o[k] shows a shadow value is waiting
  // for its channel's next period boundary.
  logic [NCH-1:0]   en_i;
  logic [NCH-1:0]   upd_i;
  logic [NCH*W-1:0] period_i;
  logic [NCH*W-1:0] duty_i;
  logic             sync_i;
  logic [NCH-1:0]   pwm_o;
  logic [NCH-1:0]   done_o;
  logic [NCH-1:0]   pend_o;

  modport master (
    output en_i, upd_i, period_i, duty_i, sync_i,
    input  pwm_o, done_o, pend_o
  );

  modport slave (
    input  en_i, upd_i, period_i, duty_i, sync_i,
    output pwm_o, done_o, pend_o
  );
endinterface

// File: rtl/servo_pwm_chan.sv
// One PWM channel: free-running counter with double-buffered period/duty.
module servo_pwm_chan
  import servo_pwm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         upd,
  input  logic         sync,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty,
  output logic         pwm,
  output logic         done,
  output logic         pend
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt;
  logic [W-1:0] p_act;
  logic [W-1:0] d_act;
  logic [W-1:0] p_sh;
  logic [W-1:0] d_sh;
  logic         running;
  logic         at_end;
  logic         boundary;

  // A boundary is any edge where a new period/duty may safely take over:
  // natural wrap, global sync, or the channel sitting idle.
  always_comb begin
    running  = en && (p_act != '0);
    at_end   = running && (cnt == p_act - ONE);
    boundary = !running || at_end || sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      p_act <= '0;
      d_act <= '0;
      p_sh  <= '0;
      d_sh  <= '0;
      pend  <= 1'b0;
      pwm   <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (!running || sync || at_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end

      pwm  <= running && (cnt < d_act);
      done <= at_end && !sync;

      // A strobe landing on a boundary bypasses the shadow entirely.
      if (upd) begin
        if (boundary) begin
          p_act <= period;
          d_act <= duty;
          pend  <= 1'b0;
        end else begin
          p_sh  <= period;
          d_sh  <= duty;
          pend  <= 1'b1;
        end
      end else if (boundary && pend) begin
        p_act <= p_sh;
        d_act <= d_sh;
        pend  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// NCH-channel servo PWM core: slices the flattened register-file buses per channel.
module servo_pwm_gen
  import servo_pwm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input logic       clk,
  input logic       rst,
  servo_pwm_if.slave bus
);

  logic [NCH-1:0] pwm;
  logic [NCH-1:0] done;
  logic [NCH-1:0] pend;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam int LSB = CH_LSB(k, W);

    servo_pwm_chan #(.W(W)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en_i[k]),
      .upd    (bus.upd_i[k]),
      .sync   (bus.sync_i),
      .period (bus.period_i[LSB +: W]),
      .duty   (bus.duty_i[LSB +: W]),
      .pwm    (pwm[k]),
      .done   (done[k]),
      .pend   (pend[k])
    );
  end

  assign bus.pwm_o  = pwm;
  assign bus.done_o = done;
  assign bus.pend_o = pend;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed-vector bench for servo_pwm_gen; outputs sampled 1 time unit after each rising edge.
module tb_servo_pwm_gen;
  import servo_pwm_pkg::*;

  localparam int NCH = 8;
  localparam int W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;

  servo_pwm_if #(.NCH(NCH), .W(W)) bus ();

  servo_pwm_gen #(.NCH(NCH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] p, input logic [W-1:0] d);
    bus.period_i[k*W +: W] = p;
    bus.duty_i[k*W +: W]   = d;
  endtask

  task automatic test_reset();
    ntests++;
    if (bus.pwm_o !== '0 || bus.done_o !== '0 || bus.pend_o !== '0) begin
      nfail++;
      $display("FAIL reset_hold: pwm=%b done=%b pend=%b required all 0", bus.pwm_o, bus.done_o, bus.pend_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // load ch0 P=10 D=3 while idle, then run
    bus.upd_i[0] = 1'b1; set_ch(0, 10, 3);
    tick();
    bus.upd_i[0] = 1'b0; bus.en_i[0] = 1'b1;
    tick(); tick();
    bus.upd_i[0] = 1'b1; set_ch(0, 7, 2);
    tick();
    bus.upd_i[0] = 1'b0;
    ntests++;
    if (bus.pwm_o[0] !== 1'b1 || bus.pend_o[0] !== 1'b1) begin
      nfail++;
      $display("FAIL pre_reset_run: pwm0=%b pend0=%b required 1 1", bus.pwm_o[0], bus.pend_o[0]);
    end
    #2 rst = 1'b1;
    #1;
    ntests++;
    if (bus.pwm_o !== '0 || bus.done_o !== '0 || bus.pend_o !== '0) begin
      nfail++;
      $display("FAIL async_reset: pwm=%b done=%b pend=%b required all 0", bus.pwm_o, bus.done_o, bus.pend_o);
    end
    @(posedge clk); #1;
    bus.en_i[0] = 1'b0;
    rst = 1'b0;
    tick();
    bus.en_i[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      ntests++;
      if (bus.pwm_o[0] !== 1'b0 || bus.done_o[0] !== 1'b0 || bus.pend_o[0] !== 1'b0) begin
        nfail++;
        $display("FAIL post_reset_idle[%0d]: pwm0=%b done0=%b pend0=%b required 0 0 0", i, bus.pwm_o[0], bus.done_o[0], bus.pend_o[0]);
      end
    end
    bus.en_i[0] = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.upd_i[0] = 1'b1; set_ch(0, 10, 3);
    tick();
    bus.upd_i[0] = 1'b0;
    ntests++;
    if (bus.pend_o[0] !== 1'b0) begin
      nfail++;
      $display("FAIL idle_bypass_pend: pend0=%b required 0", bus.pend_o[0]);
    end
    bus.en_i[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      ntests++;
      if (bus.pwm_o[0] !== ((i % 10) < 3) || bus.done_o[0] !== ((i % 10) == 9)) begin
        nfail++;
        $display("FAIL basic[%0d]: pwm0=%b done0=%b required %b %b", i, bus.pwm_o[0], bus.done_o[0], (i % 10) < 3, (i % 10) == 9);
      end
    end
  endtask

  // continues from test_basic with ch0 at cnt=0
  task automatic test_update_mid();
    for (int c = 0; c < 4; c++) begin
      tick();
      ntests++;
      if (bus.pwm_o[0] !== (c < 3)) begin
        nfail++;
        $display("FAIL upd_pre[%0d]: pwm0=%b required %b", c, bus.pwm_o[0], c < 3);
      end
    end
    bus.upd_i[0] = 1'b1; set_ch(0, 8, 6);
    tick();
    bus.upd_i[0] = 1'b0;
    for (int c = 4; c < 10; c++) begin
      if (c > 4) tick();
      ntests++;
      if (bus.pwm_o[0] !== 1'b0 || bus.pend_o[0] !== (c != 9) || bus.done_o[0] !== (c == 9)) begin
        nfail++;
        $display("FAIL upd_tail[%0d]: pwm0=%b pend0=%b done0=%b required 0 %b %b", c, bus.pwm_o[0], bus.pend_o[0], bus.done_o[0], c != 9, c == 9);
      end
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      ntests++;
      if (bus.pwm_o[0] !== ((j % 8) < 6) || bus.done_o[0] !== ((j % 8) == 7) || bus.pend_o[0] !== 1'b0) begin
        nfail++;
        $display("FAIL upd_new[%0d]: pwm0=%b done0=%b pend0=%b required %b %b 0", j, bus.pwm_o[0], bus.done_o[0], bus.pend_o[0], (j % 8) < 6, (j % 8) == 7);
      end
    end
    bus.en_i[0] = 1'b0;
    tick();
    ntests++;
    if (bus.pwm_o[0] !== 1'b0 || bus.done_o[0] !== 1'b0) begin
      nfail++;
      $display("FAIL disable: pwm0=%b done0=%b required 0 0", bus.pwm_o[0], bus.done_o[0]);
    end
  endtask

  task automatic test_boundary();
    int unsigned pv [5] = '{5, 5, 5, 1, 0};
    int unsigned dv [5] = '{0, 5, 9, 1, 3};
    logic        hi [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int n = 0; n < 5; n++) begin
      bus.en_i[1] = 1'b0; bus.upd_i[1] = 1'b1; set_ch(1, pv[n], dv[n]);
      tick();
      bus.upd_i[1] = 1'b0; bus.en_i[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
        logic exp_done;
        tick();
        exp_done = (pv[n] == 0) ? 1'b0 : ((i % pv[n]) == pv[n] - 1);
        ntests++;
        if (bus.pwm_o[1] !== hi[n] || bus.done_o[1] !== exp_done) begin
          nfail++;
          $display("FAIL boundary P=%0d D=%0d [%0d]: pwm1=%b done1=%b required %b %b", pv[n], dv[n], i, bus.pwm_o[1], bus.done_o[1], hi[n], exp_done);
        end
      end
    end
    bus.en_i[1] = 1'b0;
    tick();
  endtask

  task automatic test_sync();
    bus.upd_i[2] = 1'b1; set_ch(2, 4, 2);
    bus.upd_i[3] = 1'b1; set_ch(3, 6, 3);
    tick();
    bus.upd_i[2] = 1'b0; bus.upd_i[3] = 1'b0;
    bus.en_i[2] = 1'b1;
    repeat (4) tick();
    bus.en_i[3] = 1'b1;
    repeat (3) tick();
    // ch2 now at cnt=3 (its own wrap), ch3 at cnt=3
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    ntests++;
    if (bus.done_o[2] !== 1'b0 || bus.done_o[3] !== 1'b0) begin
      nfail++;
      $display("FAIL sync_no_done: done2=%b done3=%b required 0 0", bus.done_o[2], bus.done_o[3]);
    end
    for (int j = 0; j < 12; j++) begin
      tick();
      ntests++;
      if (bus.pwm_o[2] !== ((j % 4) < 2) || bus.done_o[2] !== ((j % 4) == 3) ||
          bus.pwm_o[3] !== ((j % 6) < 3) || bus.done_o[3] !== ((j % 6) == 5)) begin
        nfail++;
        $display("FAIL sync_align[%0d]: pwm2=%b done2=%b pwm3=%b done3=%b required %b %b %b %b", j,
                 bus.pwm_o[2], bus.done_o[2], bus.pwm_o[3], bus.done_o[3],
                 (j % 4) < 2, (j % 4) == 3, (j % 6) < 3, (j % 6) == 5);
      end
    end
    bus.en_i[2] = 1'b0; bus.en_i[3] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    // ch4: strobe exactly on the wrap cycle
    bus.upd_i[4] = 1'b1; set_ch(4, 5, 2);
    tick();
    bus.upd_i[4] = 1'b0; bus.en_i[4] = 1'b1;
    repeat (4) tick();
    bus.upd_i[4] = 1'b1; set_ch(4, 3, 1);
    tick();
    bus.upd_i[4] = 1'b0;
    ntests++;
    if (bus.pend_o[4] !== 1'b0 || bus.done_o[4] !== 1'b1 || bus.pwm_o[4] !== 1'b0) begin
      nfail++;
      $display("FAIL wrap_upd: pend4=%b done4=%b pwm4=%b required 0 1 0", bus.pend_o[4], bus.done_o[4], bus.pwm_o[4]);
    end
    for (int j = 0; j < 9; j++) begin
      tick();
      ntests++;
      if (bus.pwm_o[4] !== ((j % 3) < 1) || bus.done_o[4] !== ((j % 3) == 2) || bus.pend_o[4] !== 1'b0) begin
        nfail++;
        $display("FAIL wrap_new[%0d]: pwm4=%b done4=%b pend4=%b required %b %b 0", j, bus.pwm_o[4], bus.done_o[4], bus.pend_o[4], (j % 3) < 1, (j % 3) == 2);
      end
    end
    bus.en_i[4] = 1'b0;
    // ch5: two strobes before the wrap, last one wins
    bus.upd_i[5] = 1'b1; set_ch(5, 6, 2);
    tick();
    bus.upd_i[5] = 1'b0; bus.en_i[5] = 1'b1;
    tick();
    bus.upd_i[5] = 1'b1; set_ch(5, 4, 3);
    tick();
    set_ch(5, 5, 4);
    tick();
    bus.upd_i[5] = 1'b0;
    for (int c = 3; c < 6; c++) begin
      tick();
      ntests++;
      if (bus.pwm_o[5] !== 1'b0 || bus.pend_o[5] !== (c != 5) || bus.done_o[5] !== (c == 5)) begin
        nfail++;
        $display("FAIL double_tail[%0d]: pwm5=%b pend5=%b done5=%b required 0 %b %b", c, bus.pwm_o[5], bus.pend_o[5], bus.done_o[5], c != 5, c == 5);
      end
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      ntests++;
      if (bus.pwm_o[5] !== ((j % 5) < 4) || bus.done_o[5] !== ((j % 5) == 4)) begin
        nfail++;
        $display("FAIL double_new[%0d]: pwm5=%b done5=%b required %b %b", j, bus.pwm_o[5], bus.done_o[5], (j % 5) < 4, (j % 5) == 4);
      end
    end
    bus.en_i[5] = 1'b0;
    tick();
  endtask

  initial begin
    bus.en_i     = '0;
    bus.upd_i    = '0;
    bus.period_i = '0;
    bus.duty_i   = '0;
    bus.sync_i   = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_update_mid();
    test_boundary();
    test_sync();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
